// File: rtl/color_measure_ctrl.sv
// Colour-sensor measurement sequencer: steps the filter through R/G/B, counts
// synchronized sensor edges over a gate window per filter, publishes a coherent triple.
module color_measure_ctrl #(
  parameter int SETTLE_CYCLES = 5000,
  parameter int GATE_CYCLES   = 500000,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sensor_out,
  output logic        s2,
  output logic        s3,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        valid,
  output logic        busy
);

  localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_sat;
  logic [1:0]       ch_reg, ch_next;
  logic [1:0]       filter_next;
  logic             gate_end;

  logic             sync1_reg, sync2_reg, prev_reg;
  logic             edge_det;

  logic             s2_reg, s3_reg, busy_reg, valid_reg;
  logic [15:0]      red_reg, green_reg, blue_reg;

  // Asynchronous pin: two-stage synchronizer, then rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= sensor_out;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign edge_det = sync2_reg & ~prev_reg;
  assign cnt_sat  = (edge_det && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_W'(1) : cnt_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    gate_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          ch_next    = 2'd0;
          timer_next = '0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_reg == SETTLE_LAST) begin
          timer_next = '0;
          cnt_next   = '0;
          state_next = COUNT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      COUNT: begin
        cnt_next = cnt_sat;
        if (timer_reg == GATE_LAST) begin
          gate_end   = 1'b1;
          timer_next = '0;
          if (ch_reg == 2'd2) begin
            state_next = DONE;
          end else begin
            ch_next    = ch_reg + 2'd1;
            state_next = SETTLE;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Filter select follows the upcoming state; DONE keeps the blue setting.
  always_comb begin
    filter_next = {s2_reg, s3_reg};
    case (state_next)
      IDLE: filter_next = 2'b10;
      SETTLE, COUNT: begin
        case (ch_next)
          2'd0:    filter_next = 2'b00;
          2'd1:    filter_next = 2'b11;
          default: filter_next = 2'b01;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      cnt_reg   <= '0;
      ch_reg    <= 2'd0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
    end
  end

  // Red and green are parked in shadows; blue's final count goes straight out.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_shadow
      logic [CNT_W-1:0] shadow_reg;
      always_ff @(posedge clk) begin
        if (rst)
          shadow_reg <= '0;
        else if (gate_end && (ch_reg == 2'(gi)))
          shadow_reg <= cnt_sat;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_reg    <= 1'b1;
      s3_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      red_reg   <= '0;
      green_reg <= '0;
      blue_reg  <= '0;
    end else begin
      s2_reg    <= filter_next[1];
      s3_reg    <= filter_next[0];
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_next == DONE);
      if (gate_end && (ch_reg == 2'd2)) begin
        red_reg   <= 16'(g_shadow[0].shadow_reg);
        green_reg <= 16'(g_shadow[1].shadow_reg);
        blue_reg  <= 16'(cnt_sat);
      end
    end
  end

  assign s2    = s2_reg;
  assign s3    = s3_reg;
  assign busy  = busy_reg;
  assign valid = valid_reg;
  assign red   = red_reg;
  assign green = green_reg;
  assign blue  = blue_reg;

endmodule

// File: tb/tb_color_measure_ctrl.sv
// Bench for color_measure_ctrl: two instances (wide counter / 3-bit counter),
// table vectors plus random pulse counts checked against a cycle-timing model.
module tb_color_measure_ctrl;

  localparam int S  = 4;
  localparam int GA = 20;
  localparam int GB = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sensor, sel;
  logic start_a, start_b, sens_a, sens_b;
  logic s2_a, s3_a, valid_a, busy_a, s2_b, s3_b, valid_b, busy_b;
  logic [15:0] red_a, green_a, blue_a, red_b, green_b, blue_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign sens_a  = sensor & ~sel;
  assign sens_b  = sensor & sel;

  color_measure_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(GA), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sensor_out(sens_a),
    .s2(s2_a), .s3(s3_a), .red(red_a), .green(green_a), .blue(blue_a),
    .valid(valid_a), .busy(busy_a)
  );

  color_measure_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(GB), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sensor_out(sens_b),
    .s2(s2_b), .s3(s3_b), .red(red_b), .green(green_b), .blue(blue_b),
    .valid(valid_b), .busy(busy_b)
  );

  logic        obs_valid, obs_busy;
  logic [1:0]  obs_filter;
  logic [47:0] obs_rgb;
  assign obs_valid  = sel ? valid_b : valid_a;
  assign obs_busy   = sel ? busy_b : busy_a;
  assign obs_filter = sel ? {s2_b, s3_b} : {s2_a, s3_a};
  assign obs_rgb    = sel ? {red_b, green_b, blue_b} : {red_a, green_a, blue_a};

  int errors = 0;
  int checks = 0;
  int cnt_in [2][3];
  int exp_in [2][3];
  logic [47:0] prev_a, prev_b;

  typedef struct {
    bit b;
    int nr, ng, nb;
    int er, eg, eb;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req, input int t);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0d got=%0h want=%0h", name, sel, t, act, req);
    end
  endtask

  task automatic rand_meas(input int idx);
    int maxp, lim;
    maxp = sel ? 10 : 5;
    lim  = sel ? 7 : 65535;
    for (int c = 0; c < 3; c++) begin
      cnt_in[idx][c] = int'($urandom_range(0, maxp));
      exp_in[idx][c] = (cnt_in[idx][c] < lim) ? cnt_in[idx][c] : lim;
    end
  endtask

  // Drives nm measurements (start held when nm>1) and checks every cycle
  // against the timing rules: cycle u=0 samples start, channel c occupies
  // u in [1+c*per, (c+1)*per], DONE at u=3*per+1.
  task automatic run(input int nm, input bit mid_start, input bit mid_rst);
    int per, p, len, t_rst;
    logic [47:0] prev, tri_exp;
    per   = S + (sel ? GB : GA);
    p     = 3 * per + 2;
    len   = (nm - 1) * p + p + 8;
    t_rst = mid_rst ? (1 + 2 * per + S + 5) : -1;
    prev  = sel ? prev_b : prev_a;
    for (int t = 0; t < len; t++) begin
      int m, u;
      bit inm, after_rst, s_hi, busy_e, valid_e;
      logic [1:0] f_e;
      @(posedge clk);
      #1;
      after_rst = mid_rst && (t > t_rst);
      m   = t / p;
      u   = t % p;
      inm = (m < nm) && !after_rst;
      start = (!after_rst && (t <= (nm - 1) * p)) || (mid_start && (t == 1 + per + S + 5));
      rst   = (t == t_rst);
      s_hi  = 1'b0;
      if (inm) begin
        for (int c = 0; c < 3; c++) begin
          int d;
          d = u - (c * per + S);
          if (d >= 0 && d < 4 * cnt_in[m][c] && (d % 4) < 2) s_hi = 1'b1;
        end
      end
      sensor = s_hi;
      @(negedge clk);
      busy_e  = inm && (u >= 1);
      valid_e = inm && (u == 3 * per + 1);
      if (inm && u >= 1 && u <= 3 * per) begin
        case ((u - 1) / per)
          0:       f_e = 2'b00;
          1:       f_e = 2'b11;
          default: f_e = 2'b01;
        endcase
      end else if (inm && u == 3 * per + 1) begin
        f_e = 2'b01;
      end else begin
        f_e = 2'b10;
      end
      tri_exp = prev;
      if (after_rst) begin
        tri_exp = '0;
      end else begin
        for (int mm = 0; mm < nm; mm++)
          if (t >= mm * p + 3 * per + 1)
            tri_exp = {16'(exp_in[mm][0]), 16'(exp_in[mm][1]), 16'(exp_in[mm][2])};
      end
      chk("valid", 64'(obs_valid), 64'(valid_e), t);
      chk("busy", 64'(obs_busy), 64'(busy_e), t);
      chk("filter", 64'(obs_filter), 64'(f_e), t);
      chk("rgb", 64'(obs_rgb), 64'(tri_exp), t);
      if (t == len - 1) begin
        if (mid_rst) begin
          prev_a = '0;
          prev_b = '0;
        end else if (sel) begin
          prev_b = tri_exp;
        end else begin
          prev_a = tri_exp;
        end
      end
    end
    start  = 1'b0;
    sensor = 1'b0;
    for (int mm = 0; mm < nm; mm++)
      $display("meas sel=%0d n=%0d/%0d/%0d exp=%0d/%0d/%0d hold=%0d midstart=%0d midrst=%0d",
               sel, cnt_in[mm][0], cnt_in[mm][1], cnt_in[mm][2],
               exp_in[mm][0], exp_in[mm][1], exp_in[mm][2], nm > 1, mid_start, mid_rst);
  endtask

  task automatic load_vec(input int i);
    sel = tbl[i].b;
    cnt_in[0][0] = tbl[i].nr; cnt_in[0][1] = tbl[i].ng; cnt_in[0][2] = tbl[i].nb;
    exp_in[0][0] = tbl[i].er; exp_in[0][1] = tbl[i].eg; exp_in[0][2] = tbl[i].eb;
  endtask

  initial begin
    tbl[0] = '{b: 1'b0, nr: 5, ng: 2, nb: 4, er: 5, eg: 2, eb: 4};
    tbl[1] = '{b: 1'b0, nr: 0, ng: 0, nb: 0, er: 0, eg: 0, eb: 0};
    tbl[2] = '{b: 1'b0, nr: 5, ng: 5, nb: 5, er: 5, eg: 5, eb: 5};
    tbl[3] = '{b: 1'b0, nr: 1, ng: 0, nb: 3, er: 1, eg: 0, eb: 3};
    tbl[4] = '{b: 1'b1, nr: 10, ng: 0, nb: 0, er: 7, eg: 0, eb: 0};
    tbl[5] = '{b: 1'b1, nr: 3, ng: 9, nb: 7, er: 3, eg: 7, eb: 7};
    tbl[6] = '{b: 1'b1, nr: 0, ng: 10, nb: 6, er: 0, eg: 7, eb: 6};

    rst = 1'b1; start = 1'b0; sensor = 1'b0; sel = 1'b0;
    prev_a = '0; prev_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_idle_a", {busy_a, valid_a, s2_a, s3_a, red_a, green_a, blue_a},
          {1'b0, 1'b0, 1'b1, 1'b0, 48'd0}, i);
      chk("rst_idle_b", {busy_b, valid_b, s2_b, s3_b, red_b, green_b, blue_b},
          {1'b0, 1'b0, 1'b1, 1'b0, 48'd0}, i);
    end

    // Single measurement, then ignored mid-run start, then held start.
    load_vec(0);
    run(1, 1'b0, 1'b0);
    sel = 1'b0;
    rand_meas(0);
    run(1, 1'b1, 1'b0);
    rand_meas(0);
    rand_meas(1);
    run(2, 1'b0, 1'b0);

    for (int i = 1; i < 7; i++) begin
      load_vec(i);
      run(1, 1'b0, 1'b0);
    end

    // Reset during blue COUNT of a second measurement, then recovery.
    load_vec(0);
    run(1, 1'b0, 1'b0);
    rand_meas(0);
    run(1, 1'b0, 1'b1);
    load_vec(0);
    run(1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      sel = (i >= 3);
      rand_meas(0);
      run(1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
